mem_port_arbiter: RTL

- Shares one main-memory port between REQUESTERS processing blocks. Each block issues loads and writes of a full SIMD row (CORES*BITS bits).
- Round-robin arbitration; accepts one transaction per cycle. Issues each accepted transaction to memory the same cycle.
- Tracks the owner of every in-flight transaction through a fixed-latency pipeline and routes the response back to it.
- Sits between the processing blocks' load/write interfaces and the main memory.

---
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the processing blocks, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 16
);
  logic [REQUESTERS-1:0]        req_valid;
  logic [REQUESTERS-1:0]        req_write;
  logic [REQUESTERS*ADDR_W-1:0] req_addr;
  logic [REQUESTERS*DATA_W-1:0] req_wdata;
  logic [REQUESTERS-1:0]        req_ready;
  logic [REQUESTERS-1:0]        resp_valid;
  logic [DATA_W-1:0]            resp_rdata;
  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]            mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between requesters.
// Accepted transactions issue to memory the same cycle; a {valid, id} shift
// pipeline of MEM_LATENCY stages routes each completion back to its owner.
module mem_port_arbiter #(
  parameter int unsigned REQUESTERS  = 4,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int unsigned ID_W = $clog2(REQUESTERS);
  localparam int unsigned LAST = MEM_LATENCY - 1;

  logic [ID_W-1:0]        rr_q, rr_d;
  logic [MEM_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [ID_W-1:0]        pipe_id_q [MEM_LATENCY];
  logic [ID_W-1:0]        pipe_id_d [MEM_LATENCY];

  logic                   grant_found;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        try_id;
  logic [REQUESTERS-1:0]  grant_oh;
  logic                   sel_write;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  // Grant: first valid requester scanning upward from rr_q with wrap; depends
  // only on req_valid and rr_q, never on req_ready.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    try_id      = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      try_id = ID_W'((32'(rr_q) + k) % REQUESTERS);
      if (!grant_found && bus.req_valid[try_id]) begin
        grant_found = 1'b1;
        grant_id    = try_id;
      end
    end
    if (reset) begin
      grant_found = 1'b0;
    end
    grant_oh = '0;
    if (grant_found) begin
      grant_oh[grant_id] = 1'b1;
    end
  end

  // Issue mux: AND-OR select of the granted requester's command onto memory.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (grant_oh[i]) begin
        sel_write = bus.req_write[i];
        sel_addr  = sel_addr  | bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
    bus.req_ready = grant_oh;
    bus.mem_en    = grant_found;
    bus.mem_we    = sel_write;
    bus.mem_addr  = sel_addr;
    bus.mem_wdata = sel_write ? sel_wdata : '0;
  end

  // Next state: pointer advances past the winner; tracking pipeline shifts.
  always_comb begin
    rr_d = grant_found ? ID_W'((32'(grant_id) + 1) % REQUESTERS) : rr_q;
    pipe_valid_d    = '0;
    pipe_valid_d[0] = grant_found;
    pipe_id_d[0]    = grant_id;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_id_d[i]    = pipe_id_q[i-1];
    end
  end

  // State registers; reset drops every in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q         <= '0;
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      rr_q         <= rr_d;
      pipe_valid_q <= pipe_valid_d;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        pipe_id_q[i] <= pipe_id_d[i];
      end
    end
  end

  // Response: one-hot completion from the last stage, load data passed through.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    if (pipe_valid_q[LAST] && !reset) begin
      bus.resp_valid[pipe_id_q[LAST]] = 1'b1;
      bus.resp_rdata                  = bus.mem_rdata;
    end
  end
endmodule
